// File: rtl/mcu_psram_writer_pkg.sv
// Shared PSRAM write-path definitions: address width, page geometry, FSM encodings
// and the page-legal segment length helper.
package mcu_psram_writer_pkg;

  localparam int PSRAM_AW       = 23;
  localparam int PAGE_WORDS_DEF = 512;
  localparam int SEG_W          = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Words that fit before the next page boundary, capped by what is left of the burst.
  function automatic logic [SEG_W-1:0] seg_len(input logic [PSRAM_AW-1:0] addr,
                                               input int unsigned         remain,
                                               input int unsigned         page_words);
    int unsigned off;
    int unsigned room;
    off  = 32'(addr) & (page_words - 1);
    room = page_words - off;
    return SEG_W'((remain < room) ? remain : room);
  endfunction

endpackage

// File: rtl/mcu_psram_writer.sv
// Splits fixed-length MCU write bursts into page-legal PSRAM write commands and
// streams the FIFO head to the controller, popping the FIFO one word ahead.
module mcu_psram_writer
  import mcu_psram_writer_pkg::*;
#(
  parameter int BURST_WORDS = 32,
  parameter int PAGE_WORDS  = PAGE_WORDS_DEF
) (
  input  logic                xClk,
  input  logic                xRst_n,
  input  logic                xMcuReqWrite,
  input  logic [PSRAM_AW-1:0] xAddress,
  input  logic [15:0]         xDin,
  output logic                xRdEn,
  output logic                xRamReady,
  output logic                ramCmdValid,
  input  logic                ramCmdReady,
  output logic [PSRAM_AW-1:0] ramCmdAddr,
  output logic [SEG_W-1:0]    ramCmdLen,
  output logic [15:0]         ramWrData,
  output logic                ramWrValid,
  input  logic                ramWrReady,
  output logic                xErrReq
);

  localparam int RW = $clog2(BURST_WORDS + 1);

  logic [1:0]          state_q,  state_d;
  logic [PSRAM_AW-1:0] addr_q,   addr_d;
  logic [RW-1:0]       remain_q, remain_d;
  logic [SEG_W-1:0]    segcnt_q, segcnt_d;
  logic [SEG_W-1:0]    seg_q,    seg_d;
  logic                ready_q,  ready_d;
  logic                err_q,    err_d;

  logic wr_hs;
  logic [PSRAM_AW-1:0] addr_inc;
  logic [RW-1:0]       remain_dec;

  assign wr_hs      = (state_q == ST_DATA) && ramWrReady;
  assign addr_inc   = addr_q + PSRAM_AW'(1);
  assign remain_dec = remain_q - RW'(1);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a signal
    // unassigned; without these defaults synthesis would infer latches.
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    segcnt_d = segcnt_q;
    seg_d    = seg_q;
    err_d    = err_q | (xMcuReqWrite && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (xMcuReqWrite) begin
          addr_d   = xAddress;
          remain_d = RW'(BURST_WORDS);
          seg_d    = seg_len(xAddress, BURST_WORDS, PAGE_WORDS);
          state_d  = ST_CMD;
        end
      end
      ST_CMD: begin
        if (ramCmdReady) begin
          segcnt_d = seg_q;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ramWrReady) begin
          segcnt_d = segcnt_q - SEG_W'(1);
          remain_d = remain_dec;
          addr_d   = addr_inc;
          if (segcnt_q == SEG_W'(1)) begin
            if (remain_q == RW'(1)) begin
              state_d = ST_IDLE;
            end else begin
              // Next segment's length is latched now so the command is stable on CMD entry.
              seg_d   = seg_len(addr_inc, 32'(remain_dec), PAGE_WORDS);
              state_d = ST_CMD;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge xClk or negedge xRst_n) begin
    if (!xRst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      segcnt_q <= '0;
      seg_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge values,
      // matching real register behaviour regardless of statement order.
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      segcnt_q <= segcnt_d;
      seg_q    <= seg_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  // addr_q only moves in DATA, so it doubles as the held command address in CMD.
  assign xRamReady   = ready_q;
  assign ramCmdValid = (state_q == ST_CMD);
  assign ramCmdAddr  = addr_q;
  assign ramCmdLen   = seg_q;
  assign ramWrValid  = (state_q == ST_DATA);
  assign ramWrData   = ramWrValid ? xDin : 16'h0000;
  assign xRdEn       = wr_hs && (remain_q > RW'(1));
  assign xErrReq     = err_q;

endmodule

// File: tb/tb_mcu_psram_writer.sv
// Directed bench for mcu_psram_writer: a transaction-level model predicts commands,
// data order, pop count and handshake timing, checked every cycle on the falling edge.
module tb_mcu_psram_writer;

  localparam int N    = 32;
  localparam int PAGE = 512;

  logic        xClk;
  logic        xRst_n;
  logic        xMcuReqWrite;
  logic [22:0] xAddress;
  logic [15:0] xDin;
  logic        xRdEn;
  logic        xRamReady;
  logic        ramCmdValid;
  logic        ramCmdReady;
  logic [22:0] ramCmdAddr;
  logic [9:0]  ramCmdLen;
  logic [15:0] ramWrData;
  logic        ramWrValid;
  logic        ramWrReady;
  logic        xErrReq;

  mcu_psram_writer #(.BURST_WORDS(N), .PAGE_WORDS(PAGE)) dut (
    .xClk(xClk), .xRst_n(xRst_n), .xMcuReqWrite(xMcuReqWrite), .xAddress(xAddress),
    .xDin(xDin), .xRdEn(xRdEn), .xRamReady(xRamReady), .ramCmdValid(ramCmdValid),
    .ramCmdReady(ramCmdReady), .ramCmdAddr(ramCmdAddr), .ramCmdLen(ramCmdLen),
    .ramWrData(ramWrData), .ramWrValid(ramWrValid), .ramWrReady(ramWrReady),
    .xErrReq(xErrReq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    xClk = 1'b0;
    forever #5 xClk = ~xClk;
  end

  // Upstream FIFO: one-cycle read latency, pops only on an accepted request or xRdEn.
  logic [15:0] mem [0:N-1];
  int          rd = 0;
  logic [15:0] exp_base = 16'h0;
  bit          pop;

  initial begin
    xDin = 16'h0;
    forever begin
      @(negedge xClk);
      pop = (xMcuReqWrite && xRamReady) || xRdEn;
      @(posedge xClk);
      #1;
      if (pop) begin
        xDin = (rd < N) ? mem[rd] : 16'hDEAD;
        rd++;
      end
    end
  end

  // Controller ready lines: tied high, or random data ready plus a 5-cycle command stall.
  bit bp_mode  = 1'b0;
  int cmd_wait = 0;

  initial begin
    ramCmdReady = 1'b1;
    ramWrReady  = 1'b1;
    forever begin
      @(posedge xClk);
      #1;
      if (bp_mode) begin
        cmd_wait    = ramCmdValid ? cmd_wait + 1 : 0;
        ramCmdReady = (cmd_wait > 5);
        ramWrReady  = 1'($urandom_range(0, 1));
      end else begin
        cmd_wait    = 0;
        ramCmdReady = 1'b1;
        ramWrReady  = 1'b1;
      end
    end
  end

  // Transaction model and logs.
  bit          busy, armed, err_m, hold_valid;
  int          words_done, seg_left, rd_pulses;
  logic [22:0] hold_addr;
  logic [9:0]  hold_len;
  logic [22:0] exp_cmd_addr [$];
  int          exp_cmd_len  [$];
  logic [15:0] exp_data     [$];
  logic [22:0] log_addr     [$];
  int          log_len      [$];
  logic [15:0] log_data     [$];

  initial begin
    int  a, r, off, s;
    bit  busy_before, hs_w;
    busy = 0; armed = 0; err_m = 0; hold_valid = 0;
    words_done = 0; seg_left = 0; rd_pulses = 0;
    forever begin
      @(negedge xClk);
      if (!xRst_n) begin
        busy = 0; armed = 0; err_m = 0; hold_valid = 0;
        words_done = 0; seg_left = 0;
        exp_cmd_addr.delete(); exp_cmd_len.delete(); exp_data.delete();
      end else begin
        busy_before = busy;
        hs_w = ramWrValid && ramWrReady;
        check("ram_ready", xRamReady, armed && !busy);
        check("cmd_valid", ramCmdValid, busy && seg_left == 0);
        check("wr_valid",  ramWrValid,  busy && seg_left > 0);
        check("err_req",   xErrReq,     err_m);
        check("rd_en",     xRdEn,       hs_w && busy && words_done < N - 1);
        if (!ramWrValid) check("wr_data_gated", ramWrData, 0);
        if (hold_valid) begin
          check("cmd_addr_stable", ramCmdAddr, hold_addr);
          check("cmd_len_stable",  ramCmdLen,  hold_len);
        end

        if (ramCmdValid && ramCmdReady) begin
          log_addr.push_back(ramCmdAddr);
          log_len.push_back(int'(ramCmdLen));
          if (exp_cmd_addr.size() > 0) begin
            check("cmd_addr", ramCmdAddr, exp_cmd_addr[0]);
            check("cmd_len",  ramCmdLen,  exp_cmd_len[0]);
            seg_left = exp_cmd_len[0];
            void'(exp_cmd_addr.pop_front());
            void'(exp_cmd_len.pop_front());
          end else begin
            check("cmd_unexpected", 1, 0);
          end
        end
        hold_valid = ramCmdValid && !ramCmdReady;
        hold_addr  = ramCmdAddr;
        hold_len   = ramCmdLen;

        if (hs_w) begin
          log_data.push_back(ramWrData);
          if (exp_data.size() > 0) begin
            check("wr_data", ramWrData, exp_data[0]);
            void'(exp_data.pop_front());
          end else begin
            check("data_unexpected", 1, 0);
          end
          words_done++;
          if (seg_left > 0) seg_left--;
          if (words_done == N) busy = 0;
        end
        if (xRdEn) rd_pulses++;

        if (xMcuReqWrite) begin
          if (busy_before) begin
            err_m = 1;
          end else begin
            busy = 1; words_done = 0; seg_left = 0;
            a = int'(xAddress); r = N;
            while (r > 0) begin
              off = a % PAGE;
              s   = (r < PAGE - off) ? r : PAGE - off;
              exp_cmd_addr.push_back(23'(a));
              exp_cmd_len.push_back(s);
              a = (a + s) % (1 << 23);
              r = r - s;
            end
            for (int i = 0; i < N; i++) exp_data.push_back(16'(exp_base + i));
          end
        end
        armed = 1;
      end
    end
  end

  task automatic start_burst(input logic [22:0] addr, input logic [15:0] base);
    @(posedge xClk);
    #2;
    for (int i = 0; i < N; i++) mem[i] = 16'(base + i);
    rd       = 0;
    exp_base = base;
    log_addr.delete(); log_len.delete(); log_data.delete();
    rd_pulses    = 0;
    xAddress     = addr;
    xMcuReqWrite = 1'b1;
    @(posedge xClk);
    #2;
    xMcuReqWrite = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    repeat (2) @(posedge xClk);
    for (int i = 0; i < 3000 && !done; i++) begin
      #2;
      if (xRamReady) done = 1;
      else @(posedge xClk);
    end
    check({name, "_complete"}, done, 1);
  endtask

  task automatic check_burst(input string name, input logic [22:0] a0, input int l0,
                             input logic [22:0] a1, input int l1, input int ncmd,
                             input logic [15:0] base);
    check({name, "_ncmd"},    log_addr.size(), ncmd);
    check({name, "_c0_addr"}, log_addr[0], a0);
    check({name, "_c0_len"},  log_len[0], l0);
    if (ncmd > 1) begin
      check({name, "_c1_addr"}, log_addr[1], a1);
      check({name, "_c1_len"},  log_len[1], l1);
    end
    check({name, "_nwords"},  log_data.size(), N);
    check({name, "_first"},   log_data[0], base);
    check({name, "_last"},    log_data[N-1], 16'(base + N - 1));
    check({name, "_pops"},    rd_pulses, N - 1);
    check({name, "_leftover"}, exp_data.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"},     xRamReady,   0);
    check({name, "_cmd_valid"}, ramCmdValid, 0);
    check({name, "_wr_valid"},  ramWrValid,  0);
    check({name, "_rd_en"},     xRdEn,       0);
    check({name, "_err"},       xErrReq,     0);
    check({name, "_cmd_addr"},  ramCmdAddr,  0);
    check({name, "_cmd_len"},   ramCmdLen,   0);
    check({name, "_wr_data"},   ramWrData,   0);
  endtask

  initial begin
    bit seen;
    xRst_n       = 1'b0;
    xMcuReqWrite = 1'b0;
    xAddress     = '0;
    repeat (3) @(posedge xClk);
    #3;
    check_reset_outputs("por");
    @(posedge xClk);
    #2;
    xRst_n = 1'b1;
    repeat (2) @(posedge xClk);

    start_burst(23'h000100, 16'h1000);
    wait_idle("aligned");
    check_burst("aligned", 23'h000100, 32, 23'h0, 0, 1, 16'h1000);

    start_burst(23'h0001F8, 16'h2000);
    wait_idle("pagex");
    check_burst("pagex", 23'h0001F8, 8, 23'h000200, 24, 2, 16'h2000);

    bp_mode = 1'b1;
    start_burst(23'h0001F0, 16'h3000);
    wait_idle("bp");
    check_burst("bp", 23'h0001F0, 16, 23'h000200, 16, 2, 16'h3000);
    bp_mode = 1'b0;

    start_burst(23'h7FFFF0, 16'h7000);
    wait_idle("wrap");
    check_burst("wrap", 23'h7FFFF0, 16, 23'h000000, 16, 2, 16'h7000);

    start_burst(23'h000400, 16'h5000);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge xClk);
      #2;
      if (ramWrValid) seen = 1;
    end
    check("busy_reached_data", seen, 1);
    xAddress     = 23'h000123;
    xMcuReqWrite = 1'b1;
    @(posedge xClk);
    #2;
    xMcuReqWrite = 1'b0;
    wait_idle("busy");
    check_burst("busy", 23'h000400, 32, 23'h0, 0, 1, 16'h5000);
    check("busy_err_set", xErrReq, 1);
    repeat (5) @(posedge xClk);
    #2;
    check("busy_err_sticky", xErrReq, 1);

    start_burst(23'h000300, 16'h6000);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge xClk);
      if (log_data.size() >= 10) seen = 1;
    end
    check("rst_reached_10", seen, 1);
    @(posedge xClk);
    #2;
    xRst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge xClk);
    #2;
    xRst_n = 1'b1;

    start_burst(23'h000040, 16'h4000);
    wait_idle("post_rst");
    check_burst("post_rst", 23'h000040, 32, 23'h0, 0, 1, 16'h4000);

    repeat (3) @(posedge xClk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
